// File: rtl/uart_mem_loader_pkg.sv
// rtl/uart_mem_loader_pkg.sv - shared state encoding and error codes for the UART memory loader
package uart_mem_loader_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      WAIT_SYNC = 3'd1,
      LEN_LO    = 3'd2,
      LEN_HI    = 3'd3,
      DATA      = 3'd4,
      CSUM      = 3'd5,
      DONE      = 3'd6,
      ERR       = 3'd7
   } state_t;

   localparam logic [1:0] ERR_NONE = 2'b00;
   localparam logic [1:0] ERR_LEN  = 2'b01;
   localparam logic [1:0] ERR_CSUM = 2'b10;
   localparam logic [1:0] ERR_TMO  = 2'b11;

   localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

endpackage

// File: rtl/loader_timeout_cnt.sv
// rtl/loader_timeout_cnt.sv - idle cycle counter that flags expiry after TIMEOUT cycles without a byte
module loader_timeout_cnt #(
   parameter int TIMEOUT = 1_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expire
);

   localparam int W = $clog2(TIMEOUT + 1);

   logic [W-1:0] cnt;

   assign expire = (cnt == W'(TIMEOUT));

   // Saturates at TIMEOUT so expire stays asserted until the owner clears it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en && !expire) begin
         cnt <= cnt + W'(1);
      end
   end

endmodule

// File: rtl/uart_mem_loader.sv
// rtl/uart_mem_loader.sv - bootloader that turns a framed UART byte stream into 32-bit memory writes
module uart_mem_loader
   import uart_mem_loader_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter logic [7:0]  SYNC_BYTE = SYNC_BYTE_DEFAULT,
   parameter int          MAX_WORDS = 256,
   parameter int          TIMEOUT   = 1_000_000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   input  logic        start,
   output logic        MemWrite,
   output logic [31:0] addr,
   output logic [31:0] wdata,
   output logic        busy,
   output logic        hold,
   output logic        done,
   output logic        err,
   output logic [1:0]  err_code
);

   state_t      state;
   logic [7:0]  len_lo;
   logic [7:0]  csum;
   logic [15:0] words_left;
   logic [1:0]  byte_idx;
   logic [23:0] asm_q;

   logic        tmo_en;
   logic        tmo_clr;
   logic        tmo_expire;
   logic [15:0] len_cnt;
   logic        len_bad;
   logic        last_pulse;
   logic        csum_byte;

   assign tmo_en  = (state == LEN_LO) || (state == LEN_HI) || (state == DATA) || (state == CSUM);
   assign tmo_clr = rx_valid || !tmo_en;

   assign len_cnt = {rx_data, len_lo};
   assign len_bad = (len_cnt == 16'd0) || ({1'b0, len_cnt} > 17'(MAX_WORDS));

   // The checksum byte may arrive while the final word is still being strobed out.
   assign last_pulse = (state == DATA) && MemWrite && (words_left == 16'd1);
   assign csum_byte  = rx_valid && ((state == CSUM) || last_pulse);

   assign hold = busy;

   loader_timeout_cnt #(
      .TIMEOUT (TIMEOUT)
   ) u_tmo (
      .clk    (clk),
      .rst    (rst),
      .clr    (tmo_clr),
      .en     (tmo_en),
      .expire (tmo_expire)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         MemWrite   <= 1'b0;
         addr       <= 32'd0;
         wdata      <= 32'd0;
         busy       <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
         err_code   <= ERR_NONE;
         len_lo     <= 8'd0;
         csum       <= 8'd0;
         words_left <= 16'd0;
         byte_idx   <= 2'd0;
         asm_q      <= 24'd0;
      end else begin
         MemWrite <= 1'b0;
         case (state)
            IDLE, DONE, ERR: begin
               if (start) begin
                  state    <= WAIT_SYNC;
                  done     <= 1'b0;
                  err      <= 1'b0;
                  err_code <= ERR_NONE;
                  csum     <= 8'd0;
                  busy     <= 1'b1;
               end
            end
            WAIT_SYNC: begin
               if (rx_valid && (rx_data == SYNC_BYTE)) begin
                  state <= LEN_LO;
               end
            end
            LEN_LO: begin
               if (rx_valid) begin
                  len_lo <= rx_data;
                  csum   <= csum ^ rx_data;
                  state  <= LEN_HI;
               end
            end
            LEN_HI: begin
               if (rx_valid) begin
                  csum <= csum ^ rx_data;
                  if (len_bad) begin
                     state    <= ERR;
                     err      <= 1'b1;
                     err_code <= ERR_LEN;
                     busy     <= 1'b0;
                  end else begin
                     state      <= DATA;
                     words_left <= len_cnt;
                     addr       <= BASE_ADDR;
                     byte_idx   <= 2'd0;
                  end
               end
            end
            DATA: begin
               if (MemWrite) begin
                  addr       <= addr + 32'd4;
                  words_left <= words_left - 16'd1;
                  if (words_left == 16'd1) begin
                     state <= CSUM;
                  end
               end
               if (rx_valid && !last_pulse) begin
                  csum     <= csum ^ rx_data;
                  byte_idx <= byte_idx + 2'd1;
                  case (byte_idx)
                     2'd0:    asm_q[7:0]   <= rx_data;
                     2'd1:    asm_q[15:8]  <= rx_data;
                     2'd2:    asm_q[23:16] <= rx_data;
                     default: begin
                        wdata    <= {rx_data, asm_q};
                        MemWrite <= 1'b1;
                     end
                  endcase
               end
            end
            default: begin
            end
         endcase

         if (csum_byte) begin
            busy <= 1'b0;
            if (rx_data == csum) begin
               state <= DONE;
               done  <= 1'b1;
            end else begin
               state    <= ERR;
               err      <= 1'b1;
               err_code <= ERR_CSUM;
            end
         end

         if (tmo_en && tmo_expire && !rx_valid) begin
            state    <= ERR;
            err      <= 1'b1;
            err_code <= ERR_TMO;
            busy     <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_mem_loader.sv
// tb/tb_uart_mem_loader.sv - self-checking bench for uart_mem_loader against a frame-level model
module tb_uart_mem_loader;

   localparam logic [31:0] BASE = 32'h0000_0000;
   localparam int          TMO  = 100;

   typedef logic [7:0] bq_t[$];

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [7:0]  rx_data = 8'd0;
   logic        rx_valid = 1'b0;
   logic        start = 1'b0;
   logic        MemWrite;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        busy;
   logic        hold;
   logic        done;
   logic        err;
   logic [1:0]  err_code;

   int checks = 0;
   int errors = 0;

   logic [63:0] obs_q[$];
   logic [63:0] exp_q[$];
   logic        exp_done;
   logic        exp_err;
   logic [1:0]  exp_code;

   always #5 clk = ~clk;

   uart_mem_loader #(
      .BASE_ADDR (BASE),
      .SYNC_BYTE (8'hA5),
      .MAX_WORDS (256),
      .TIMEOUT   (TMO)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .start    (start),
      .MemWrite (MemWrite),
      .addr     (addr),
      .wdata    (wdata),
      .busy     (busy),
      .hold     (hold),
      .done     (done),
      .err      (err),
      .err_code (err_code)
   );

   always @(negedge clk) begin
      if (MemWrite) obs_q.push_back({addr, wdata});
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic bq_t make_frame(input int n);
      bq_t f;
      logic [7:0] x;
      logic [7:0] b;
      f.push_back(8'hA5);
      f.push_back(n[7:0]);
      f.push_back(n[15:8]);
      x = n[7:0] ^ n[15:8];
      for (int i = 0; i < 4 * n; i++) begin
         b = 8'($urandom);
         f.push_back(b);
         x = x ^ b;
      end
      f.push_back(x);
      return f;
   endfunction

   task automatic model(input bq_t f);
      int i;
      int n;
      int p;
      logic [7:0] x;
      exp_q.delete();
      exp_done = 1'b0;
      exp_err  = 1'b0;
      exp_code = 2'b00;
      i = 0;
      while (i < f.size() && f[i] != 8'hA5) i++;
      if (i + 2 >= f.size()) return;
      n = int'(f[i+1]) + 256 * int'(f[i+2]);
      x = f[i+1] ^ f[i+2];
      if (n == 0 || n > 256) begin
         exp_err  = 1'b1;
         exp_code = 2'b01;
         return;
      end
      for (int w = 0; w < n; w++) begin
         p = i + 3 + 4 * w;
         if (p + 3 >= f.size()) return;
         exp_q.push_back({BASE + 32'(4 * w), f[p+3], f[p+2], f[p+1], f[p]});
         x = x ^ f[p] ^ f[p+1] ^ f[p+2] ^ f[p+3];
      end
      p = i + 3 + 4 * n;
      if (p >= f.size()) return;
      if (f[p] == x) exp_done = 1'b1;
      else begin
         exp_err  = 1'b1;
         exp_code = 2'b10;
      end
   endtask

   task automatic send(input bq_t f, input int gap_max);
      foreach (f[k]) begin
         rx_data  = f[k];
         rx_valid = 1'b1;
         @(negedge clk);
         rx_valid = 1'b0;
         repeat ($urandom_range(gap_max, 0)) @(negedge clk);
      end
   endtask

   task automatic arm();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("arm busy", busy, 1);
      check("arm hold", hold, 1);
      check("arm flags", {done, err, err_code}, 0);
   endtask

   task automatic wait_idle();
      int c = 0;
      while (busy && c < 400) begin
         @(negedge clk);
         c++;
      end
      check("idle within budget", busy, 0);
      repeat (2) @(negedge clk);
   endtask

   task automatic run(input string tag, input bq_t f, input int gap_max, output int base);
      arm();
      base = obs_q.size();
      model(f);
      send(f, gap_max);
      wait_idle();
      check({tag, " write count"}, 64'(obs_q.size() - base), 64'(exp_q.size()));
      for (int k = 0; k < exp_q.size(); k++) begin
         if (base + k < obs_q.size()) check({tag, " write"}, obs_q[base + k], exp_q[k]);
      end
      check({tag, " done"}, done, exp_done);
      check({tag, " err"}, err, exp_err);
      check({tag, " err_code"}, err_code, exp_code);
      check({tag, " hold"}, hold, 0);
   endtask

   initial begin
      bq_t f;
      int  base;

      repeat (3) @(negedge clk);
      check("reset outputs", {MemWrite, addr, wdata, busy, hold, done, err, err_code}, 0);
      rst = 1'b1;
      @(negedge clk);

      f = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB, 8'hCC, 8'hDD,
            8'h02 ^ 8'h00 ^ 8'h11 ^ 8'h22 ^ 8'h33 ^ 8'h44 ^ 8'hAA ^ 8'hBB ^ 8'hCC ^ 8'hDD};
      run("nominal", f, 2, base);
      if (obs_q.size() >= base + 2) begin
         check("nominal word0", obs_q[base], {32'h0, 32'h4433_2211});
         check("nominal word1", obs_q[base + 1], {32'h4, 32'hDDCC_BBAA});
      end
      check("nominal done flag", done, 1);

      f = make_frame(1);
      f.push_front(8'h5A);
      f.push_front(8'hFF);
      f.push_front(8'h00);
      run("junk", f, 1, base);

      f = '{8'hA5, 8'h00, 8'h00};
      run("len0", f, 1, base);
      f = '{8'hA5, 8'h01, 8'h01};
      run("len257", f, 1, base);

      f = make_frame(1);
      f[f.size() - 1] = ~f[f.size() - 1];
      run("badcsum", f, 1, base);

      arm();
      f = '{8'hA5, 8'h01};
      send(f, 0);
      repeat (95) @(negedge clk);
      check("tmo not yet", {busy, err}, 2'b10);
      repeat (10) @(negedge clk);
      check("tmo err", err, 1);
      check("tmo err_code", err_code, 2'b11);
      check("tmo busy", {busy, hold, done}, 0);
      f = make_frame(2);
      run("after tmo", f, 1, base);

      f = make_frame(3);
      run("b2b", f, 0, base);

      for (int r = 0; r < 4; r++) begin
         f = make_frame(int'($urandom_range(6, 1)));
         run("random", f, 3, base);
      end

      arm();
      base = obs_q.size();
      f = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22};
      send(f, 0);
      #2 rst = 1'b0;
      #1 check("async reset outputs", {MemWrite, addr, wdata, busy, hold, done, err, err_code}, 0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      f = '{8'h33, 8'h44, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h00};
      send(f, 0);
      repeat (10) @(negedge clk);
      check("no write after reset", 64'(obs_q.size() - base), 0);
      check("idle after reset", {busy, done, err}, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
